// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: edge-detected request lines, pending/mask registers, 4-phase intr/int_ack handshake.
// Define INTR_TIMER_EN to add a periodic down-counter as the lowest-priority source (pending/mask bit NUM_SRC).
module intr_ctrl #(
  parameter int          NUM_SRC   = 4,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0FF0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               intr,
  input  logic               int_ack,
  input  logic [31:0]        Addr,
  input  logic [31:0]        D_In,
  input  logic               io_cs,
  input  logic               io_wr,
  input  logic               io_rd,
  output logic [31:0]        D_Out
);

`ifdef INTR_TIMER_EN
  localparam int PW = NUM_SRC + 1;
`else
  localparam int PW = NUM_SRC;
`endif

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t             state, state_nx;
  logic               sel, wr_en, rd_en, do_ack;
  logic [NUM_SRC-1:0] irq_q;
  logic [PW-1:0]      pending, mask, active, set_bits, clr_bits, ack_onehot;
  logic [3:0]         ack_id, vec_id;
  logic               vec_valid;
  logic [31:0]        timer_rd, rd_data;

  // A simultaneous write and read is treated as a write only.
  assign sel    = io_cs && (Addr[31:4] == ADDR_BASE[31:4]);
  assign wr_en  = sel && io_wr;
  assign rd_en  = sel && io_rd && !io_wr;
  assign active = pending & mask;
  assign intr   = (state == REQ);

`ifdef INTR_TIMER_EN
  logic [31:0] reload, count;
  logic        timer_hit;
  logic [1:0]  unused_bits;

  assign timer_hit   = (reload != 32'd0) && (count == 32'd0);
  assign set_bits    = {timer_hit, irq_in & ~irq_q};
  assign timer_rd    = count;
  assign unused_bits = Addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      reload <= '0;
      count  <= '0;
    end else if (wr_en && Addr[3:2] == 2'd3) begin
      reload <= D_In;
      count  <= D_In;
    end else if (reload != 32'd0) begin
      count <= timer_hit ? reload : count - 32'd1;
    end
  end
`else
  logic [33-PW:0] unused_bits;

  assign set_bits    = irq_in & ~irq_q;
  assign timer_rd    = '0;
  assign unused_bits = {Addr[1:0], D_In[31:PW]};
`endif

  // Scan from the top so the lowest set bit (highest priority) is left standing.
  always_comb begin
    ack_id     = '0;
    ack_onehot = '0;
    for (int i = PW - 1; i >= 0; i--) begin
      if (active[i]) begin
        ack_id        = 4'(i);
        ack_onehot    = '0;
        ack_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    do_ack   = 1'b0;
    case (state)
      IDLE: if (active != '0 && !int_ack) state_nx = REQ;
      REQ: begin
        if (active == '0) begin
          state_nx = IDLE;
        end else if (int_ack) begin
          do_ack   = 1'b1;
          state_nx = ACK;
        end
      end
      ACK:     if (!int_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    clr_bits = do_ack ? ack_onehot : '0;
    if (wr_en && Addr[3:2] == 2'd0) clr_bits = clr_bits | D_In[PW-1:0];
  end

  always_comb begin
    rd_data = '0;
    case (Addr[3:2])
      2'd0:    rd_data = {{(32-PW){1'b0}}, pending};
      2'd1:    rd_data = {{(32-PW){1'b0}}, mask};
      2'd2:    rd_data = {vec_valid, 27'd0, vec_id};
      default: rd_data = timer_rd;
    endcase
  end

  // New requests win over a same-cycle clear of the same bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      irq_q     <= '0;
      pending   <= '0;
      mask      <= '0;
      vec_valid <= 1'b0;
      vec_id    <= '0;
      D_Out     <= '0;
    end else begin
      state   <= state_nx;
      irq_q   <= irq_in;
      pending <= (pending & ~clr_bits) | set_bits;
      if (wr_en && Addr[3:2] == 2'd1) mask <= D_In[PW-1:0];
      if (do_ack) begin
        vec_valid <= 1'b1;
        vec_id    <= ack_id;
      end else if (rd_en && Addr[3:2] == 2'd2) begin
        vec_valid <= 1'b0;
      end
      D_Out <= rd_en ? rd_data : 32'd0;
    end
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Memory-mapped interrupt controller on the CPU's data bus, directly upstream of the CPU interrupt input.
- Edge-detects external request lines, latches them into a pending register and applies a mask register.
- Raises intr to the CPU with a 4-phase intr/int_ack handshake and latches the serviced source ID into a readable vector register.

Parameters:
- NUM_SRC, 4, number of external request lines (1..8); bit 0 has the highest priority.
- ADDR_BASE, 32'h0000_0FF0, base byte address of the 16-byte register window.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- irq_in  input  NUM_SRC  external request lines; rising edge sets pending.
- intr  output  1  interrupt request to CPU.
- int_ack  input  1  interrupt acknowledge from CPU.
- Addr  input  32  byte address from CPU.
- D_In  input  32  write data from CPU.
- io_cs  input  1  chip select; qualified by Addr[31:4]==ADDR_BASE[31:4].
- io_wr  input  1  write strobe.
- io_rd  input  1  read strobe.
- D_Out  output  32  registered read data.

Behaviour:
- Reset: intr=0, D_Out=0, pending=0, mask=0, vector=0, edge-detect history=0, FSM=IDLE. Applies mid-handshake: intr drops the cycle after reset is sampled.
- Edge detect: irq_q <= irq_in each cycle; rise = irq_in & ~irq_q sets pending bits.
- Registers (Addr[3:2]):
  - 0 PENDING: read pending; write 1 to clear per bit.
  - 1 MASK: read/write; 1 = enabled.
  - 2 VECTOR: read-only; bit31 = valid, [3:0] = last acked ID. Reading clears valid.
  - 3 TIMER: reload value (see optional feature); reads 0 and writes are ignored without the feature.
- Write: io_cs&io_wr&sel commits at the clock edge.
- Read: io_cs&io_rd&sel; D_Out valid on the next cycle. D_Out=0 in cycles following a non-read.
- Simultaneous io_wr and io_rd: the write has priority and D_Out=0.
- Unused high bits read 0.
- FSM, with active = pending & mask:
  - IDLE: intr=0. If active!=0 and int_ack==0, go to REQ.
  - REQ: intr=1. On int_ack==1: ID = lowest set bit of active; vector <= {1'b1,27'b0,ID}; pending[ID] cleared; go to ACK. intr=0 from the next cycle.
  - ACK: intr=0. Wait for int_ack==0, then go to IDLE.
- In REQ, if active becomes 0 (mask or W1C), go to IDLE with intr=0. A later int_ack is ignored and vector is unchanged.
- Same-cycle set and clear of one pending bit: set wins. This covers a rise together with a W1C, or a rise together with an ack clear.
- Re-request: a bit still pending after ack re-raises intr 2 cycles after int_ack falls. The cycle sequence is ACK→IDLE→REQ.
- int_ack high while in IDLE is ignored and blocks leaving IDLE.

Optional Feature:
- Macro INTR_TIMER_EN.
- Defined: adds a 32-bit down-counter as pending bit NUM_SRC, the lowest priority, with mask bit NUM_SRC.
  - A write to TIMER loads both reload and count.
  - When reload!=0, count decrements each cycle. At count==0 it sets pending[NUM_SRC] and reloads, giving a period of reload+1 cycles.
  - reload==0 disables the timer.
  - TIMER reads return the current count.
- Undefined: no counter. Pending and mask are NUM_SRC bits wide, and TIMER reads 0.

Test Plan:
1. Reset, write MASK=0xF, pulse irq_in[2] → intr=1 within 2 cycles. Assert int_ack → intr=0 next cycle. VECTOR reads 0x8000_0002 with 1-cycle latency, then reads 0x0000_0002.
2. Pulse irq_in[3] and irq_in[1] together → first ack yields ID 1. After int_ack falls, intr re-rises and the second ack yields ID 3.
3. MASK=0, pulse irq_in[0] → intr stays 0 and PENDING reads 0x1. Write MASK=0x1 → intr=1. Write PENDING=0x1 before ack → intr=0, FSM returns to IDLE, VECTOR is unchanged.
4. Hold irq_in[0] high for 10 cycles → only one pending set. Rise in the same cycle as a W1C of bit 0 → bit stays set.
5. Assert reset while in REQ → intr=0 next cycle, all registers 0, and a subsequent int_ack has no effect.
6. (INTR_TIMER_EN) MASK=0x10, TIMER=9 → intr asserted every 10 cycles when acked promptly, and VECTOR ID=4.
